mips_multicycle_control: RTL and testbench

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

---
 rtl/mips_multicycle_control.sv | 196 +++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute
// for lw, sw, R-type ALU ops, beq, addi and j. Unsupported opcodes and
// R-type functs are flagged with a single-cycle IllegalOp/InstrDone pulse.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [3:0] ALUControl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       InstrDone,
  output logic       IllegalOp
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluAnd = 4'b0011;
  localparam logic [3:0] AluOr  = 4'b0100;
  localparam logic [3:0] AluXor = 4'b0101;

  state_e state_q, state_d;
  logic   pc_write;
  logic   branch;

  // State register; reset wins over any pending transition.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // Next-state and output decode; reset forces the idle output pattern.
  always_comb begin
    state_d    = state_q;
    ALUControl = AluAdd;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    PCSrc      = 2'b00;
    InstrDone  = 1'b0;
    IllegalOp  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;

    unique case (state_q)
      StFetch: begin
        IRWrite  = 1'b1;
        ALUSrcB  = 2'b01;
        pc_write = 1'b1;
        state_d  = StDecode;
      end
      StDecode: begin
        // Speculative branch target: PC+4 + (imm << 2)
        ALUSrcB = 2'b11;
        case (Op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            state_d   = StFetch;
            IllegalOp = 1'b1;
            InstrDone = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        IorD    = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StMemWr: begin
        IorD      = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StExecute: begin
        ALUSrcA = 1'b1;
        state_d = StAluWb;
        case (Funct)
          6'b100000: ALUControl = AluAdd;
          6'b100010: ALUControl = AluSub;
          6'b100100: ALUControl = AluAnd;
          6'b100101: ALUControl = AluOr;
          6'b100110: ALUControl = AluXor;
          default: begin
            // Abort before write-back so no register is touched
            IllegalOp = 1'b1;
            InstrDone = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StAluWb: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        ALUSrcA    = 1'b1;
        ALUControl = AluSub;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        InstrDone  = 1'b1;
        state_d    = StFetch;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        PCSrc     = 2'b10;
        pc_write  = 1'b1;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase

    if (reset) begin
      ALUControl = AluAdd;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      PCSrc      = 2'b00;
      InstrDone  = 1'b0;
      IllegalOp  = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
    end
  end

  // PC update: unconditional writes, or taken branch
  assign PCEn = pc_write | (branch & Zero);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class
// cycle by cycle and compares the full output bundle to hand-built vectors.
module tb_mips_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic [3:0] ALUControl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic [1:0] PCSrc;
  logic       PCEn, InstrDone, IllegalOp;

  int n_cmp = 0;
  int n_bad = 0;

  mips_multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Zero       (Zero),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .PCSrc      (PCSrc),
    .PCEn       (PCEn),
    .InstrDone  (InstrDone),
    .IllegalOp  (IllegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ALUControl, ALUSrcA, ALUSrcB, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
  //  RegWrite, PCSrc, PCEn, InstrDone, IllegalOp}
  logic [17:0] outv;
  assign outv = {ALUControl, ALUSrcA, ALUSrcB, IorD, MemWrite, IRWrite, RegDst,
                 MemtoReg, RegWrite, PCSrc, PCEn, InstrDone, IllegalOp};

  function automatic logic [17:0] ov(input logic [3:0] alu, input logic sa,
                                     input logic [1:0] sb, input logic iord,
                                     input logic mw, input logic irw,
                                     input logic rd, input logic m2r,
                                     input logic rw, input logic [1:0] ps,
                                     input logic pcen, input logic done,
                                     input logic ill);
    return {alu, sa, sb, iord, mw, irw, rd, m2r, rw, ps, pcen, done, ill};
  endfunction

  task automatic check(input string tag, input logic [17:0] got,
                       input logic [17:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Sample mid-cycle, then advance to the next falling edge
  task automatic cyc(input string tag, input logic [17:0] exp);
    #1;
    check(tag, outv, exp);
    @(negedge clk);
  endtask

  logic [17:0] e_rst, e_fetch, e_dec, e_dec_ill, e_memadr, e_memrd, e_memwb;
  logic [17:0] e_memwr, e_ex_sub, e_ex_ill, e_aluwb, e_br_t, e_br_nt;
  logic [17:0] e_addiex, e_addiwb, e_jump;

  initial begin
    e_rst     = ov(4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    e_fetch   = ov(4'b0010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0);
    e_dec     = ov(4'b0010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    e_dec_ill = ov(4'b0010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1);
    e_memadr  = ov(4'b0010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    e_memrd   = ov(4'b0010, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    e_memwb   = ov(4'b0010, 0, 2'b00, 0, 0, 0, 0, 1, 1, 2'b00, 0, 1, 0);
    e_memwr   = ov(4'b0010, 0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 0, 1, 0);
    e_ex_sub  = ov(4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    e_ex_ill  = ov(4'b0010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1);
    e_aluwb   = ov(4'b0010, 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0, 1, 0);
    e_br_t    = ov(4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 1, 1, 0);
    e_br_nt   = ov(4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0, 1, 0);
    e_addiex  = ov(4'b0010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    e_addiwb  = ov(4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1, 0);
    e_jump    = ov(4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1, 1, 0);

    reset = 1'b1;
    Op    = 6'b000000;
    Funct = 6'b000000;
    Zero  = 1'b0;
    @(negedge clk);
    cyc("reset.a", e_rst);
    Op = 6'b100011;
    cyc("reset.b", e_rst);

    // lw: 5 cycles
    reset = 1'b0;
    cyc("lw.fetch", e_fetch);
    cyc("lw.decode", e_dec);
    cyc("lw.memadr", e_memadr);
    cyc("lw.memrd", e_memrd);
    cyc("lw.memwb", e_memwb);

    // sw: 4 cycles
    Op = 6'b101011;
    cyc("sw.fetch", e_fetch);
    cyc("sw.decode", e_dec);
    cyc("sw.memadr", e_memadr);
    cyc("sw.memwr", e_memwr);

    // R-type sub: 4 cycles
    Op = 6'b000000; Funct = 6'b100010;
    cyc("sub.fetch", e_fetch);
    cyc("sub.decode", e_dec);
    cyc("sub.execute", e_ex_sub);
    cyc("sub.aluwb", e_aluwb);

    // beq taken then not taken: 3 cycles each
    Op = 6'b000100; Zero = 1'b1;
    cyc("beq1.fetch", e_fetch);
    cyc("beq1.decode", e_dec);
    cyc("beq1.branch", e_br_t);
    Zero = 1'b0;
    cyc("beq0.fetch", e_fetch);
    cyc("beq0.decode", e_dec);
    cyc("beq0.branch", e_br_nt);

    // addi: 4 cycles
    Op = 6'b001000;
    cyc("addi.fetch", e_fetch);
    cyc("addi.decode", e_dec);
    cyc("addi.ex", e_addiex);
    cyc("addi.wb", e_addiwb);

    // Illegal opcode aborts from DECODE
    Op = 6'b111111;
    cyc("illop.fetch", e_fetch);
    cyc("illop.decode", e_dec_ill);

    // Illegal funct aborts from EXECUTE, never writes back
    Op = 6'b000000; Funct = 6'b000000;
    cyc("illfn.fetch", e_fetch);
    cyc("illfn.decode", e_dec);
    cyc("illfn.execute", e_ex_ill);

    // lw aborted by reset in MEMRD
    Op = 6'b100011;
    cyc("abort.fetch", e_fetch);
    cyc("abort.decode", e_dec);
    cyc("abort.memadr", e_memadr);
    reset = 1'b1;
    cyc("abort.memrd_rst", e_rst);
    Op = 6'b000010;
    reset = 1'b0;

    // j after abort: 3 cycles, then back to fetch
    cyc("j.fetch", e_fetch);
    cyc("j.decode", e_dec);
    cyc("j.jump", e_jump);
    cyc("j.next_fetch", e_fetch);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
